product_bcd_converter: RTL
==========================

// Module: product_bcd_converter
// PURPOSE
//   Downstream of the 8x8 signed multiplier: takes the 16-bit two's-complement
//   product {Aval,Bval} and converts it to sign + 5 BCD digits with an iterative
//   double-dabble FSM. Digits, sign and blank mask drive the decimal hex-display
//   stage in place of raw Aval/Bval hex. Conversion is started by a one-cycle start pulse.
// PARAMETERS
//   WIDTH   16  product width in bits, two's complement
//   DIGITS  5   BCD digits out; 10**DIGITS must be >= 2**(WIDTH-1)
// PORTS
//   Clk       in   1         system clock, rising edge
//   Reset     in   1         asynchronous, active-high reset
//   start     in   1         request conversion; sampled only in IDLE
//   Aval      in   8         product upper byte (from multiplier A register)
//   Bval      in   8         product lower byte (from multiplier B register)
//   busy      out  1         1 in SHIFT and DONE states
//   done      out  1         one-cycle pulse; outputs valid and updated
//   sign      out  1         1 = product negative
//   bcd       out  4*DIGITS  digit i at bcd[4i+3:4i], digit 0 = ones
//   blank     out  DIGITS    bit i = 1 if digit i is a leading zero (bit 0 always 0)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, counter=0, shift reg=0, busy=0, done=0,
//     sign=0, bcd=0, blank={DIGITS-1{1'b1},1'b0} (display "0").
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start=1 at edge E0 -> capture P={Aval,Bval}; mag = P[15] ? -P : P
//     (16-bit unsigned; 0x8000 -> 32768); BCD scratch=0; counter=0; goto SHIFT.
//     start=0 -> stay; outputs hold.
//   SHIFT: each edge: every scratch digit >=5 gets +3 (all digits corrected in
//     parallel, from pre-shift values), then {scratch,mag} shifted left 1.
//     counter increments; on the edge where counter==WIDTH-1 (16th shift, E16)
//     goto DONE and register sign, bcd, blank from the final result.
//   DONE: done=1 for exactly one cycle (between E16 and E17), busy=1; next edge -> IDLE.
//   Latency: start sampled at E0 -> done high after E16; new start accepted at E17.
//   start while busy: ignored, no queuing, no effect on current conversion.
//   Outputs sign/bcd/blank change only at the DONE entry edge; hold otherwise.
//   Aval/Bval are sampled only at E0; later changes do not affect result.
//   blank: scan from digit DIGITS-1 down; bit set while digit==0 and all
//     higher digits are blank; digit 0 never blank. sign for zero product = 0.
//   Reset mid-conversion: abort, all outputs to reset values, no done pulse.
//   No combinational path from inputs to outputs.
// TESTING
//   {Aval,Bval}=0x019D, start pulse -> done after 17 edges; sign=0, bcd=0x00413, blank=5'b11000.
//   0xFE63 -> sign=1, bcd=0x00413; 0xFFE0 -> sign=1, bcd=0x00032, blank=5'b11100.
//   0x8000 -> sign=1, bcd=0x32768, blank=0; 0x7FFF -> sign=0, bcd=0x32767.
//   0x0000 -> sign=0, bcd=0x00000, blank=5'b11110; back-to-back start at E17 accepted.
//   start re-pulsed at E5 with 0x1234 on inputs -> ignored, result still 0x019D's 00413.
//   Reset high at E8 of a conversion -> busy=0, outputs at reset values, no done pulse.

Source files
------------

// File: rtl/product_bcd_converter_if.sv
// Handshake and result bus between the multiplier front end and the BCD converter.
// The master drives the start request and product bytes; the slave returns the status and the decimal result.
interface product_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH/2-1:0]    aval;
    logic [WIDTH/2-1:0]    bval;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, aval, bval,
        input  busy, done, sign, bcd, blank
    );

    modport slave (
        input  start, aval, bval,
        output busy, done, sign, bcd, blank
    );
endinterface

// File: rtl/product_bcd_converter.sv
// Converts the signed product {aval,bval} into sign, BCD digits and a leading-zero blank mask
// using one double-dabble shift per clock.
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    product_bcd_converter_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_count;
    logic [WIDTH-1:0]      r_mag;
    logic [4*DIGITS-1:0]   r_scratch;
    logic                  r_neg;
    logic                  r_sign;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [DIGITS-1:0]     r_blank;

    logic [WIDTH-1:0]      w_product;
    logic [WIDTH-1:0]      w_abs;
    logic                  w_last;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_shifted;
    logic [DIGITS-1:0]     w_zero;
    logic [DIGITS-1:0]     w_blank;

    // The most negative product negates to itself, which reads correctly as unsigned 2**(WIDTH-1).
    assign w_product = {bus.aval, bus.bval};
    assign w_abs     = w_product[WIDTH-1] ? (~w_product + WIDTH'(1)) : w_product;
    assign w_last    = (r_count == CW'(WIDTH - 1));

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                      (r_scratch[4*gi +: 4] + 4'd3) : r_scratch[4*gi +: 4];
        end
    endgenerate

    assign w_shifted = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_mag[WIDTH-1]};

    // Blank mask is derived from the post-shift value so it lands together with the final digits.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            assign w_zero[gi] = (w_shifted[4*gi +: 4] == 4'd0);
            if (gi == 0) begin : g_ones
                assign w_blank[gi] = 1'b0;
            end else if (gi == DIGITS - 1) begin : g_top
                assign w_blank[gi] = w_zero[gi];
            end else begin : g_mid
                assign w_blank[gi] = w_zero[gi] & w_blank[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count   <= '0;
            r_mag     <= '0;
            r_scratch <= '0;
            r_neg     <= 1'b0;
            r_sign    <= 1'b0;
            r_bcd     <= '0;
            r_blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mag     <= w_abs;
                        r_neg     <= w_product[WIDTH-1];
                        r_scratch <= '0;
                        r_count   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_shifted;
                    r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
                    r_count   <= r_count + CW'(1);
                    if (w_last) begin
                        r_sign  <= r_neg;
                        r_bcd   <= w_shifted;
                        r_blank <= w_blank;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.sign  = r_sign;
    assign bus.bcd   = r_bcd;
    assign bus.blank = r_blank;
endmodule
